// File: rtl/program_loader_if.sv
// Byte-stream loader bus: receiver bytes and start request in, memory write strobes and status out.
// The slave modport is the loader's view; master is the driving/observing side.
interface program_loader_if #(
    parameter int NB_BYTE    = 8,
    parameter int NB_ADDRESS = 7
);
    logic                  i_start;
    logic [NB_BYTE-1:0]    i_rx_data;
    logic                  i_rx_valid;
    logic                  o_mem_reset;
    logic [NB_BYTE-1:0]    o_write_data;
    logic                  o_write_enable;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic [NB_ADDRESS-2:0] o_instr_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_mem_reset, o_write_data, o_write_enable, o_busy, o_done, o_error, o_instr_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_mem_reset, o_write_data, o_write_enable, o_busy, o_done, o_error, o_instr_count
    );
endinterface

// File: rtl/program_loader.sv
// Instruction-memory loader: clears memory, forwards bytes as write strobes, stops on an aligned HALT word.
// Define PROGRAM_LOADER_TIMEOUT_EN to add an inter-byte watchdog that ends a stalled load in ERROR.
module program_loader #(
    parameter int                 NB_DATA          = 32,
    parameter int                 NB_BYTE          = 8,
    parameter int                 N_INSTRUCTIONS   = 32,
    parameter int                 NB_ADDRESS       = 7,
    parameter logic [NB_DATA-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF
`ifdef PROGRAM_LOADER_TIMEOUT_EN
    ,
    parameter int                 TIMEOUT_CYCLES   = 1_000_000
`endif
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    program_loader_if.slave bus
);
    localparam int NB_LANE = $clog2(NB_DATA / NB_BYTE);
    localparam logic [NB_ADDRESS:0]   BYTE_CAP = (NB_ADDRESS + 1)'(N_INSTRUCTIONS * (NB_DATA / NB_BYTE));
    localparam logic [NB_ADDRESS:0]   BCNT_ONE = 1;
    localparam logic [NB_ADDRESS-2:0] WCNT_ONE = 1;

    typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_LOAD, ST_DONE, ST_ERROR} state_t;

    state_t                state_q, state_d;
    logic [NB_ADDRESS:0]   byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0]    word_q, word_d;
    logic [NB_ADDRESS-2:0] instr_count_q, instr_count_d;
    logic [NB_BYTE-1:0]    write_data_q, write_data_d;
    logic                  write_enable_q, write_enable_d;
    logic                  mem_reset_q, mem_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

`ifdef PROGRAM_LOADER_TIMEOUT_EN
    localparam int               NB_TMR    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NB_TMR-1:0] TMR_ONE   = 1;
    localparam logic [NB_TMR-1:0] TMR_LIMIT = NB_TMR'(TIMEOUT_CYCLES);
    logic [NB_TMR-1:0] timer_q, timer_d;
`endif

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        instr_count_d  = instr_count_q;
        write_data_d   = write_data_q;
        write_enable_d = 1'b0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
        timer_d        = '0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.i_start) begin
                    state_d       = ST_CLEAR;
                    byte_cnt_d    = '0;
                    word_d        = '0;
                    instr_count_d = '0;
                end
            end
            // Memory is being wiped this cycle, so any byte arriving now is dropped.
            ST_CLEAR: state_d = ST_LOAD;
            ST_LOAD: begin
`ifdef PROGRAM_LOADER_TIMEOUT_EN
                timer_d = timer_q + TMR_ONE;
`endif
                if (bus.i_rx_valid) begin
                    write_data_d   = bus.i_rx_data;
                    write_enable_d = 1'b1;
                    word_d         = {word_q[NB_DATA-NB_BYTE-1:0], bus.i_rx_data};
                    byte_cnt_d     = byte_cnt_q + BCNT_ONE;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
                    timer_d        = '0;
`endif
                    // HALT is only recognised on word boundaries; it takes priority over a full memory.
                    if (byte_cnt_d[NB_LANE-1:0] == '0) begin
                        instr_count_d = instr_count_q + WCNT_ONE;
                        if (word_d == HALT_INSTRUCTION) begin
                            state_d = ST_DONE;
                        end else if (byte_cnt_d == BYTE_CAP) begin
                            state_d = ST_ERROR;
                        end
                    end
                end
`ifdef PROGRAM_LOADER_TIMEOUT_EN
                else if (timer_d == TMR_LIMIT) begin
                    state_d = ST_ERROR;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        mem_reset_d = (state_d == ST_CLEAR);
        busy_d      = (state_d == ST_CLEAR) || (state_d == ST_LOAD);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            instr_count_q  <= '0;
            write_data_q   <= '0;
            write_enable_q <= 1'b0;
            mem_reset_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
            timer_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            instr_count_q  <= instr_count_d;
            write_data_q   <= write_data_d;
            write_enable_q <= write_enable_d;
            mem_reset_q    <= mem_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
            timer_q        <= timer_d;
`endif
        end
    end

    assign bus.o_mem_reset    = mem_reset_q;
    assign bus.o_write_data   = write_data_q;
    assign bus.o_write_enable = write_enable_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_error        = error_q;
    assign bus.o_instr_count  = instr_count_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomised self-checking bench for program_loader against a per-cycle behavioural model of the byte stream.
// Build with PROGRAM_LOADER_TIMEOUT_EN defined to exercise the watchdog with a 16-cycle limit.
module tb_program_loader;
    localparam int TMO = 16;

    logic i_clock;
    logic i_reset_n;
    int   n_checks;
    int   n_fail;

    program_loader_if #(.NB_BYTE(8), .NB_ADDRESS(7)) bus ();

    program_loader #(
        .NB_DATA(32), .NB_BYTE(8), .N_INSTRUCTIONS(32), .NB_ADDRESS(7),
        .HALT_INSTRUCTION(32'hFFFFFFFF)
`ifdef PROGRAM_LOADER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .bus      (bus)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Reference model: which phase the load is in, plus the full byte stream accepted so far.
    bit         m_clearing, m_loading, m_done, m_error, m_we, m_mr;
    logic [7:0] m_wd;
    int         m_count, m_idle;
    logic [7:0] m_stream[$];

    task automatic model_reset();
        m_clearing = 0; m_loading = 0; m_done = 0; m_error = 0;
        m_we = 0; m_mr = 0; m_wd = 8'h00; m_count = 0; m_idle = 0;
        m_stream.delete();
    endtask

    task automatic model_cycle(input bit start, input bit valid, input logic [7:0] data);
        int          n;
        logic [31:0] w;
        m_we = 0;
        if (m_clearing) begin
            m_clearing = 0;
            m_loading  = 1;
            m_idle     = 0;
        end else if (!m_loading) begin
            if (start) begin
                m_clearing = 1; m_done = 0; m_error = 0; m_count = 0;
                m_stream.delete();
            end
        end else if (valid) begin
            m_we = 1; m_wd = data; m_idle = 0;
            m_stream.push_back(data);
            n = m_stream.size();
            if (n % 4 == 0) begin
                w = {m_stream[n-4], m_stream[n-3], m_stream[n-2], m_stream[n-1]};
                m_count++;
                if (w == 32'hFFFFFFFF) begin
                    m_loading = 0; m_done = 1;
                end else if (n == 128) begin
                    m_loading = 0; m_error = 1;
                end
            end
        end else begin
`ifdef PROGRAM_LOADER_TIMEOUT_EN
            m_idle++;
            if (m_idle == TMO) begin
                m_loading = 0; m_error = 1;
            end
`endif
        end
        m_mr = m_clearing;
    endtask

    function automatic logic [18:0] exp_vec();
        return {m_mr, m_we, m_wd, (m_clearing || m_loading), m_done, m_error, 6'(m_count)};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {bus.o_mem_reset, bus.o_write_enable, bus.o_write_data, bus.o_busy,
                bus.o_done, bus.o_error, bus.o_instr_count};
    endfunction

    // One clock: inputs held across the edge, outputs sampled 1 time unit after it.
    task automatic tick(input bit start, input bit valid, input logic [7:0] data);
        bus.i_start    = start;
        bus.i_rx_valid = valid;
        bus.i_rx_data  = data;
        @(posedge i_clock);
        #1;
        model_cycle(start, valid, data);
    endtask

    task automatic test_reset();
        bus.i_start = 0; bus.i_rx_valid = 0; bus.i_rx_data = 8'h00;
        i_reset_n = 1'b1;
        #2 i_reset_n = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
        model_reset();
        n_checks++;
        if (obs_vec() !== 19'h0) begin
            n_fail++; $display("FAIL reset_state: outputs %h required 0", obs_vec());
        end
        i_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 8'($urandom()));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL idle_ignore: outputs %h required %h", obs_vec(), exp_vec());
            end
        end
        tick(1, 0, 8'h00);
        tick(0, 0, 8'h00);
        for (int i = 0; i < 6; i++) tick(0, 1, 8'(8'h30 + i));
        n_checks++;
        if (bus.o_busy !== 1'b1 || bus.o_write_enable !== 1'b1) begin
            n_fail++; $display("FAIL midload_setup: busy %b we %b required 1 1", bus.o_busy, bus.o_write_enable);
        end
        #3 i_reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec() !== 19'h0) begin
            n_fail++; $display("FAIL async_reset: outputs %h required 0", obs_vec());
        end
        @(posedge i_clock);
        #1 i_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 8'($urandom()));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL post_reset: outputs %h required %h", obs_vec(), exp_vec());
            end
        end
        $display("reset: async reset mid-load returned all outputs to 0");
    endtask

    task automatic test_basic_load();
        logic [7:0] prog[8];
        int         n_mr, n_we;
        prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        n_mr = 0; n_we = 0;
        tick(1, 0, 8'h00);
        n_mr += int'(bus.o_mem_reset);
        tick(0, 0, 8'h00);
        n_mr += int'(bus.o_mem_reset);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, prog[i]);
            n_mr += int'(bus.o_mem_reset);
            n_we += int'(bus.o_write_enable);
            n_checks++;
            if (bus.o_write_enable !== 1'b1 || bus.o_write_data !== prog[i]) begin
                n_fail++; $display("FAIL basic_byte%0d: we %b data %h required 1 %h",
                                   i, bus.o_write_enable, bus.o_write_data, prog[i]);
            end
        end
        n_checks++;
        if (n_mr != 1 || n_we != 8 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 ||
            bus.o_error !== 1'b0 || bus.o_instr_count !== 6'd2) begin
            n_fail++; $display("FAIL basic_status: mr %0d we %0d done %b busy %b err %b cnt %0d required 1 8 1 0 0 2",
                               n_mr, n_we, bus.o_done, bus.o_busy, bus.o_error, bus.o_instr_count);
        end
        tick(0, 0, 8'h00);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL basic_hold: outputs %h required %h", obs_vec(), exp_vec());
        end
        $display("basic: 8 bytes written, instr_count %0d done %b", bus.o_instr_count, bus.o_done);
    endtask

    task automatic test_overflow();
        int n_we;
        n_we = 0;
        tick(1, 0, 8'h00);
        tick(0, 0, 8'h00);
        for (int i = 0; i < 129; i++) begin
            tick(0, 1, 8'h00);
            n_we += int'(bus.o_write_enable);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL overflow_byte%0d: outputs %h required %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (n_we != 128 || bus.o_error !== 1'b1 || bus.o_done !== 1'b0 || bus.o_instr_count !== 6'd32) begin
            n_fail++; $display("FAIL overflow_status: strobes %0d err %b done %b cnt %0d required 128 1 0 32",
                               n_we, bus.o_error, bus.o_done, bus.o_instr_count);
        end
        $display("overflow: %0d strobes, error %b", n_we, bus.o_error);
    endtask

    task automatic test_halt_last();
        logic [31:0] w;
        tick(1, 0, 8'h00);
        tick(0, 0, 8'h00);
        for (int k = 0; k < 32; k++) begin
            w = (k == 31) ? 32'hFFFFFFFF : $urandom();
            if (k != 31 && w == 32'hFFFFFFFF) w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                tick(0, 1, w[31:24]);
                w = w << 8;
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL halt_last_w%0d: outputs %h required %h", k, obs_vec(), exp_vec());
                end
            end
        end
        n_checks++;
        if (bus.o_done !== 1'b1 || bus.o_error !== 1'b0 || bus.o_instr_count !== 6'd32) begin
            n_fail++; $display("FAIL halt_last_status: done %b err %b cnt %0d required 1 0 32",
                               bus.o_done, bus.o_error, bus.o_instr_count);
        end
        $display("halt_last: done %b error %b count %0d", bus.o_done, bus.o_error, bus.o_instr_count);
    endtask

    task automatic test_restart_ignores();
        logic [7:0] tail[8];
        int         n_mr;
        tail = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        n_mr = 0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 8'($urandom()));
            n_checks++;
            if (bus.o_write_enable !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL done_ignore: outputs %h required %h", obs_vec(), exp_vec());
            end
        end
        tick(1, 0, 8'h00);
        n_checks++;
        if (bus.o_mem_reset !== 1'b1 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL restart_clear: mr %b done %b busy %b required 1 0 1",
                               bus.o_mem_reset, bus.o_done, bus.o_busy);
        end
        tick(1, 1, 8'hAA);
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.o_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL clear_drop: outputs %h required %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 8; i++) begin
            tick(1, 1, tail[i]);
            n_mr += int'(bus.o_mem_reset);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL load_start_ignore%0d: outputs %h required %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (n_mr != 0 || bus.o_done !== 1'b1 || bus.o_instr_count !== 6'd2) begin
            n_fail++; $display("FAIL restart_status: mr %0d done %b cnt %0d required 0 1 2",
                               n_mr, bus.o_done, bus.o_instr_count);
        end
        $display("restart: reload finished, done %b count %0d", bus.o_done, bus.o_instr_count);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q[$];
        logic [31:0] w;
        int          nw;
        bit          v;
        for (int p = 0; p < 6; p++) begin
            nw = $urandom_range(1, 20);
            q.delete();
            for (int k = 0; k < nw; k++) begin
                w = (k == nw - 1) ? 32'hFFFFFFFF : $urandom();
                if (k != nw - 1 && w == 32'hFFFFFFFF) w = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    q.push_back(w[31:24]);
                    w = w << 8;
                end
            end
            tick(1, 0, 8'h00);
            tick(0, 0, 8'h00);
            while (q.size() > 0) begin
                v = (p < 2) || ($urandom_range(0, 3) != 0);
                if (v) tick($urandom_range(0, 7) == 0, 1, q.pop_front());
                else   tick(0, 0, 8'($urandom()));
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL random_p%0d: outputs %h required %h", p, obs_vec(), exp_vec());
                end
            end
            n_checks++;
            if (bus.o_done !== 1'b1 || bus.o_error !== 1'b0 || bus.o_instr_count !== 6'(nw)) begin
                n_fail++; $display("FAIL random_p%0d_status: done %b err %b cnt %0d required 1 0 %0d",
                                   p, bus.o_done, bus.o_error, bus.o_instr_count, nw);
            end
            $display("program %0d: %0d words loaded, done %b", p, nw, bus.o_done);
        end
    endtask

    task automatic test_timeout();
        int first_err;
        first_err = -1;
        tick(1, 0, 8'h00);
        tick(0, 0, 8'h00);
        for (int i = 0; i < 3; i++) tick(0, 1, 8'(8'h40 + i));
        for (int i = 1; i <= 40; i++) begin
            tick(0, 0, 8'h00);
            if (first_err < 0 && bus.o_error === 1'b1) first_err = i;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL timeout_cyc%0d: outputs %h required %h", i, obs_vec(), exp_vec());
            end
        end
`ifdef PROGRAM_LOADER_TIMEOUT_EN
        n_checks++;
        if (first_err != TMO || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_latency: error after %0d cycles busy %b required %0d 0",
                               first_err, bus.o_busy, TMO);
        end
`else
        n_checks++;
        if (first_err != -1 || bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL no_timeout: error after %0d cycles busy %b required none 1",
                               first_err, bus.o_busy);
        end
`endif
        $display("timeout: stalled load, error %b busy %b", bus.o_error, bus.o_busy);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        test_reset();
        test_basic_load();
        test_overflow();
        test_halt_last();
        test_restart_ignores();
        test_back_to_back();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Front-end writer for the byte-addressed instruction memory.
- Takes a byte stream from the serial receiver (one-cycle `i_rx_valid` strobes).
- Clears the memory and write pointer, then forwards each byte as a one-cycle write strobe.
- Assembles bytes into 32-bit words, MSB first, and stops when the HALT word has been written.
- Reports completion, capacity overflow and progress to the debug unit, which starts pipeline execution only after `o_done`.

## Interface
- `NB_DATA`, 32, instruction width
- `NB_BYTE`, 8, byte width
- `N_INSTRUCTIONS`, 32, memory capacity in words
- `NB_ADDRESS`, 7, memory byte-address width (log2 of `N_INSTRUCTIONS*4`)
- `HALT_INSTRUCTION`, 32'hFFFFFFFF, end-of-program word
- `TIMEOUT_CYCLES`, 1_000_000, inter-byte watchdog limit (used only with the macro)

Ports:
- `i_clock` in 1: clock, rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: begin a load; level or pulse.
- `i_rx_data` in `NB_BYTE`: received byte.
- `i_rx_valid` in 1: one-cycle strobe; `i_rx_data` is valid this cycle.
- `o_mem_reset` out 1: one-cycle synchronous clear to the instruction memory.
- `o_write_data` out `NB_BYTE`: byte to write.
- `o_write_enable` out 1: one-cycle write strobe; the memory auto-increments its pointer on it.
- `o_busy` out 1: high in CLEAR and LOAD.
- `o_done` out 1: HALT written; level, held.
- `o_error` out 1: capacity exceeded or timeout; level, held.
- `o_instr_count` out `NB_ADDRESS-1`: complete words written, HALT included.

## Operation
States: IDLE, CLEAR, LOAD, DONE, ERROR.
- **IDLE** → CLEAR on `i_start`.
- **DONE / ERROR**
  - → CLEAR on `i_start`.
  - `o_done` / `o_error` are cleared on entry to CLEAR.
- **CLEAR**
  - Lasts exactly one cycle; `o_mem_reset`=1.
  - Zeroes the byte counter, word counter, assembly register and status flags.
  - → LOAD unconditionally.
  - An `i_rx_valid` in this cycle is dropped.
- **LOAD**, on each `i_rx_valid`:
  - register `i_rx_data` into `o_write_data`;
  - pulse `o_write_enable`;
  - shift the byte into the 32-bit assembly register (first byte lands in bits 31:24);
  - increment the byte counter (`NB_ADDRESS+1` bits, no wrap).
- **LOAD**, when the 4th byte of a word is accepted:
  - increment `o_instr_count`;
  - if the assembled word equals `HALT_INSTRUCTION` → DONE;
  - else if the byte counter equals `N_INSTRUCTIONS*4` → ERROR;
  - else stay in LOAD.
- HALT in the final slot (bytes 124..127 at defaults) → DONE, not ERROR.
- A HALT pattern that is not word-aligned is not detected. Detection happens only on byte counts that are multiples of 4.
- `i_start` in CLEAR or LOAD: ignored.
- `i_rx_valid` in IDLE, DONE or ERROR: ignored; no write is issued.
- Partial word at end of stream (no HALT): stay in LOAD, unless the watchdog is enabled.
- Reset mid-load: immediate return to IDLE with all outputs at reset values. The memory contents are left as-is; the next load's CLEAR wipes them.

## Timing
- Reset values: state IDLE, all outputs 0, all counters 0.
- All outputs are registered.
- `o_write_enable`/`o_write_data`: 1 cycle after the accepting `i_rx_valid` edge.
- `o_mem_reset`: high during the cycle after the `i_start` edge.
- `o_done` / `o_error` / `o_instr_count` update on the same edge as the final write strobe. The HALT write is issued in the same cycle `o_done` rises.
- `o_busy` falls on that same edge.
- Back-to-back `i_rx_valid` on consecutive cycles is supported: one write per cycle, no stalls.
- No write strobe is ever issued in the same cycle as `o_mem_reset`.

## Configuration
- Macro: `PROGRAM_LOADER_TIMEOUT_EN`.
- **Defined:**
  - a cycle counter runs in LOAD and clears on each accepted byte;
  - when it reaches `TIMEOUT_CYCLES`, state → ERROR and `o_error`=1;
  - the counter is held at 0 outside LOAD.
- **Undefined:**
  - no counter is built;
  - LOAD waits indefinitely;
  - ERROR is reachable only by capacity overflow.

## Test plan
- **Reset:** assert `i_reset_n`=0 asynchronously mid-LOAD → next sample shows IDLE, every output 0, no further strobes.
- **Basic load:** `i_start`, then bytes 0x20,0x01,0x00,0x05 followed by FF,FF,FF,FF:
  - `o_mem_reset` pulses once;
  - 8 write strobes carry those bytes in order, each 1 cycle after its `i_rx_valid`;
  - `o_instr_count`=2 and `o_done`=1 on the 8th strobe;
  - `o_busy`=0.
- **Overflow:** 128 bytes of 0x00 → 128 strobes; `o_error`=1 with `o_instr_count`=32; byte 129 produces no strobe.
- **HALT in last slot:** 31 non-HALT words, then FFFFFFFF → `o_done`=1, `o_error`=0, `o_instr_count`=32.
- **Restart / ignores:**
  - bytes in IDLE and in DONE produce no strobe;
  - `i_start` during LOAD does not re-pulse `o_mem_reset`;
  - `i_start` in DONE clears `o_done` and re-pulses `o_mem_reset`.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=16):** 3 bytes, then silence → `o_error`=1 exactly 16 cycles after the last accepted byte. With the macro undefined, the same stimulus stays in LOAD.
